uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the serial bit rate; BIT_CYCLES = CLK_FREQ/BAUD (integer division), and BIT_CYCLES SHALL be >= 2.
REQ-003 SHALL have port clk  input  1  system clock, all state updated on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fifo_empty  input  1  TX FIFO empty flag.
REQ-006 SHALL have port fifo_data  input  8  TX FIFO head byte, combinationally valid whenever fifo_empty=0.
REQ-007 SHALL have port fifo_pop  output  1  pop request to TX FIFO, one-cycle pulse.
REQ-008 SHALL have port tx  output  1  serial line, 8N1, idle high, registered.
REQ-009 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at frame completion, registered.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP; tx_busy = (state != IDLE).
REQ-012 SHALL drive fifo_pop combinationally as (state==IDLE && fifo_empty==0); it is never high outside IDLE.
REQ-013 On the clock edge where fifo_pop=1: latch fifo_data into an 8-bit shift register, clear the baud counter to 0, clear the bit index to 0, set tx=0, and enter START.
REQ-014 SHALL keep a baud counter 0..BIT_CYCLES-1; each of START, each DATA bit, and STOP lasts exactly BIT_CYCLES clocks.
REQ-015 At START end (counter=BIT_CYCLES-1): set tx=data[0], clear the counter, and enter DATA.
REQ-016 In DATA, at each bit end: if bit index<7, increment the index and set tx to the next bit (LSB first); if index=7, set tx=1 and enter STOP.
REQ-017 At STOP end: enter IDLE, keep tx=1, and pulse tx_done=1 for exactly one clock.
REQ-018 SHALL start back-to-back frames with no gap beyond one IDLE cycle: one frame occupies 10*BIT_CYCLES+1 clocks, measured from pop to pop.
REQ-019 SHALL ignore fifo_empty and fifo_data outside IDLE; a FIFO push mid-frame SHALL NOT affect the frame in flight.
REQ-020 SHALL have a stable transmitted byte equal to the value latched at the pop edge.
REQ-021 With fifo_empty=1 in IDLE: tx=1, fifo_pop=0, and the FSM SHALL remain in IDLE indefinitely.
REQ-022 Counter width SHALL be $clog2(BIT_CYCLES) and the bit index width SHALL be 3 bits; there SHALL be no wrap beyond the terminal values.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, tx=1, tx_done=0, counter=0, bit index=0, and shift register=0; fifo_pop SHALL therefore be 0 while rst=1.
REQ-024 Reset mid-frame SHALL abort the frame: tx returns high asynchronously, no tx_done is issued, and the popped byte is lost (not re-requested).
REQ-025 After rst deasserts, the first pop SHALL occur on the first clock with fifo_empty=0.

Verification (CLK_FREQ=100, BAUD=10 -> BIT_CYCLES=10)
REQ-026 Reset/idle: assert rst, release, hold fifo_empty=1 for 200 clocks -> tx=1, fifo_pop=0, tx_busy=0, tx_done=0 throughout.
REQ-027 Single byte: fifo_data=8'hA5, fifo_empty=0 for one cycle -> one pop pulse; tx = 0,1,0,1,0,0,1,0,1,1 each held 10 clocks; tx_done pulses exactly 100 clocks after the pop edge.
REQ-028 Back-to-back: FIFO model preloaded with 8'h00, 8'hFF, 8'h3C -> three pops spaced exactly 101 clocks apart; a receiver model decodes 00, FF, 3C; tx_busy drops for one cycle between frames.
REQ-029 Mid-frame change: start 8'h55, change fifo_data to 8'hAA during DATA -> line carries 55; no extra pop until STOP completes.
REQ-030 Reset mid-frame: assert rst at bit 4 of 8'hC3 -> tx=1 asynchronously, no tx_done; after release with fifo_empty=0 a fresh frame starts with a full 10-clock start bit.
REQ-031 Integration: uart_tx connected to the team FIFO, push 16 bytes 0x00..0x0F -> serial decode matches in order, FIFO ends empty, and no pop occurs while empty.

Source files
------------

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx
//
// 8N1 UART transmitter that pulls bytes from a show-ahead TX FIFO.
// In IDLE the head byte is popped when the FIFO is not empty. A frame is
// one start bit (0), eight data bits sent LSB first, and one stop bit (1).
// Each bit is held for BIT_CYCLES = CLK_FREQ / BAUD clocks. A frame takes
// 10*BIT_CYCLES clocks. Back-to-back frames are separated by one IDLE
// cycle, in which the next pop happens.
//
// Parameters
//   CLK_FREQ   clk frequency in Hz
//   BAUD       serial bit rate; CLK_FREQ / BAUD must be at least 2
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   fifo_empty  TX FIFO empty flag
//   fifo_data   TX FIFO head byte, valid whenever fifo_empty = 0
//   fifo_pop    one-cycle pop request, only ever high in IDLE
//   tx          serial line, idle high, registered
//   tx_busy     high while a frame is in progress (state != IDLE)
//   tx_done     one-cycle pulse at the end of the stop bit, registered
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    // Guard keeps the width legal even for a misconfigured BIT_CYCLES of 1.
    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    localparam logic [2:0] IDX_ZERO = 3'd0;
    localparam logic [2:0] IDX_ONE  = 3'd1;
    localparam logic [2:0] IDX_LAST = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Registered state
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             done_r;

    // Next-state values
    logic [1:0]       state_s;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       idx_s;
    logic [7:0]       shift_s;
    logic             tx_s;
    logic             done_s;

    logic             pop_s;
    logic             cnt_last_s;
    logic [2:0]       idx_inc_s;

    // Pop is qualified with rst so no byte can be consumed while reset is held
    assign pop_s      = (state_r == ST_IDLE) && !fifo_empty && !rst;
    assign cnt_last_s = (cnt_r == CNT_LAST);
    assign idx_inc_s  = idx_r + IDX_ONE;

    assign fifo_pop = pop_s;
    assign tx       = tx_r;
    assign tx_busy  = (state_r != ST_IDLE);
    assign tx_done  = done_r;

    // Frame sequencing: next state, baud counter, bit index, line level
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        tx_s    = tx_r;
        done_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tx_s = 1'b1;
                if (pop_s) begin
                    // The byte is captured here and held unchanged for the
                    // whole frame, so later FIFO activity cannot disturb it.
                    shift_s = fifo_data;
                    cnt_s   = CNT_ZERO;
                    idx_s   = IDX_ZERO;
                    tx_s    = 1'b0;
                    state_s = ST_START;
                end else begin
                    cnt_s   = CNT_ZERO;
                    idx_s   = IDX_ZERO;
                end
            end

            ST_START: begin
                if (cnt_last_s) begin
                    tx_s    = shift_r[0];
                    cnt_s   = CNT_ZERO;
                    state_s = ST_DATA;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_last_s) begin
                    cnt_s = CNT_ZERO;
                    if (idx_r != IDX_LAST) begin
                        // Bits are picked by index; the held byte never shifts.
                        idx_s = idx_inc_s;
                        tx_s  = shift_r[idx_inc_s];
                    end else begin
                        tx_s    = 1'b1;
                        state_s = ST_STOP;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_STOP: begin
                tx_s = 1'b1;
                if (cnt_last_s) begin
                    cnt_s   = CNT_ZERO;
                    idx_s   = IDX_ZERO;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end

            default: begin
                // Unreachable with a 2-bit encoding; recover to a quiet line
                tx_s    = 1'b1;
                cnt_s   = CNT_ZERO;
                idx_s   = IDX_ZERO;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset to an idle, high line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= IDX_ZERO;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
            done_r  <= done_s;
        end
    end

endmodule
